// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU (operand register stage, result+flags register stage).
// Build option: define ALU_SAT_EN for saturating ADD/SUB; the default build wraps modulo 2^WIDTH.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Negative,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
  } alu_res_t;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Result and raw carry/overflow for one operand set; saturation is applied after the flags are formed.
  function automatic alu_res_t alu_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [3:0]       sel
  );
    alu_res_t             r;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     divisor;
    r.res   = ZERO;
    r.carry = 1'b0;
    r.ovf   = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    prod    = {ZERO, a} * {ZERO, b};
    divisor = (b == ZERO) ? ONE : b;
    case (sel)
      4'h0: begin
        r.carry = sum[WIDTH];
        r.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
        r.res   = sum[WIDTH] ? ONES : sum[WIDTH-1:0];
`else
        r.res   = sum[WIDTH-1:0];
`endif
      end
      4'h1: begin
        r.carry = diff[WIDTH];
        r.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
        r.res   = diff[WIDTH] ? ZERO : diff[WIDTH-1:0];
`else
        r.res   = diff[WIDTH-1:0];
`endif
      end
      4'h2: begin
        r.res = prod[WIDTH-1:0];
        r.ovf = (prod[2*WIDTH-1:WIDTH] != ZERO);
      end
      4'h3: begin
        r.res = (b == ZERO) ? ONES : (a / divisor);
        r.ovf = (b == ZERO);
      end
      4'h4: begin
        r.res   = {a[WIDTH-2:0], 1'b0};
        r.carry = a[WIDTH-1];
      end
      4'h5: begin
        r.res   = {1'b0, a[WIDTH-1:1]};
        r.carry = a[0];
      end
      4'h6: r.res = {a[WIDTH-2:0], a[WIDTH-1]};
      4'h7: r.res = {a[0], a[WIDTH-1:1]};
      4'h8: r.res = a & b;
      4'h9: r.res = a | b;
      4'hA: r.res = a ^ b;
      4'hB: r.res = ~(a | b);
      4'hC: r.res = ~(a & b);
      4'hD: r.res = ~(a ^ b);
      4'hE: r.res = {{(WIDTH-1){1'b0}}, (a > b)};
      4'hF: r.res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: r.res = ZERO;
    endcase
    return r;
  endfunction

  logic             s1_valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       sel_r;
  logic             s2_valid_r;
  logic             s1_adv_s;
  logic             s2_adv_s;
  alu_res_t         alu_s;
  logic             zero_s;
  logic             neg_s;

  // Handshake: a stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    s2_adv_s = !s2_valid_r || out_ready;
    s1_adv_s = !s1_valid_r || s2_adv_s;
    in_ready = s1_adv_s;
  end

  // Stage-2 datapath: evaluate the operation held in stage 1 and derive Zero/Negative from the final result.
  always_comb begin
    alu_s  = alu_eval(a_r, b_r, sel_r);
    zero_s = (alu_s.res == ZERO);
    neg_s  = alu_s.res[WIDTH-1];
  end

  // Stage 1: operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      a_r        <= ZERO;
      b_r        <= ZERO;
      sel_r      <= 4'h0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        a_r   <= A;
        b_r   <= B;
        sel_r <= ALU_Sel;
      end
    end
  end

  // Stage 2: result/flag register; the outputs are forced to zero whenever no result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      ALU_Out    <= ZERO;
      CarryOut   <= 1'b0;
      Zero       <= 1'b0;
      Overflow   <= 1'b0;
      Negative   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        ALU_Out  <= alu_s.res;
        CarryOut <= alu_s.carry;
        Zero     <= zero_s;
        Overflow <= alu_s.ovf;
        Negative <= neg_s;
      end else begin
        ALU_Out  <= ZERO;
        CarryOut <= 1'b0;
        Zero     <= 1'b0;
        Overflow <= 1'b0;
        Negative <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_r;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8); expected results are queued at accept
// and compared at delivery against an arithmetic reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;
  logic       Zero;
  logic       Overflow;
  logic       Negative;
  logic       out_valid;
  logic       out_ready;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .CarryOut(CarryOut),
    .Zero(Zero), .Overflow(Overflow), .Negative(Negative),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  logic [11:0] exp_q[$];
  logic [7:0]  ref_q[$];
  int compared = 0;
  int mismatched = 0;
  int delivered = 0;
  int accepted = 0;
  logic        hold_pend = 1'b0;
  logic [11:0] hold_val = 12'h000;
  logic [7:0]  sweep_ref [16] = '{8'h19, 8'h05, 8'h96, 8'h01, 8'h1E, 8'h07, 8'h1E, 8'h87,
                                  8'h0A, 8'h0F, 8'h05, 8'hF0, 8'hF5, 8'hFA, 8'h01, 8'h00};

  // Reference model written with integer arithmetic; packs {result, C, Z, V, N}.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    int ua, ub, sa, sb, t;
    logic [7:0] r;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r = 8'h00; c = 1'b0; o = 1'b0; t = 0;
    case (sel)
      4'd0: begin
        t = ua + ub; c = (t > 255); o = ((sa + sb) > 127) || ((sa + sb) < -128); r = 8'(t);
`ifdef ALU_SAT_EN
        if (c) r = 8'hFF;
`endif
      end
      4'd1: begin
        t = ua - ub; c = (ua < ub); o = ((sa - sb) > 127) || ((sa - sb) < -128); r = 8'(t);
`ifdef ALU_SAT_EN
        if (c) r = 8'h00;
`endif
      end
      4'd2: begin t = ua * ub; r = 8'(t); o = (t > 255); end
      4'd3: begin
        if (ub == 0) begin r = 8'hFF; o = 1'b1; end
        else r = 8'(ua / ub);
      end
      4'd4: begin r = 8'(ua * 2); c = (ua >= 128); end
      4'd5: begin r = 8'(ua / 2); c = (ua % 2 == 1); end
      4'd6: r = 8'(ua * 2 + ua / 128);
      4'd7: r = 8'(ua / 2 + (ua % 2) * 128);
      4'd8: r = a & b;
      4'd9: r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b);
      4'd12: r = ~(a & b);
      4'd13: r = ~(a ^ b);
      4'd14: r = (ua > ub) ? 8'h01 : 8'h00;
      4'd15: r = (ua == ub) ? 8'h01 : 8'h00;
      default: r = 8'h00;
    endcase
    return {r, c, (r == 8'h00), o, r[7]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (deliver/compare, hold check, accept/push), then step past posedge.
  task automatic tick();
    logic [11:0] obs;
    logic [11:0] e;
    @(negedge clk);
    obs = {ALU_Out, CarryOut, Zero, Overflow, Negative};
    if (hold_pend) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {20'd0, obs}, {20'd0, hold_val});
    end
    hold_pend = out_valid && !out_ready;
    hold_val = obs;
    if (!out_valid) check("idle_zero", {20'd0, obs}, 32'd0);
    if (out_valid && out_ready) begin
      delivered++;
      if (exp_q.size() == 0) check("spurious_out", {31'd0, out_valid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("result", {20'd0, obs}, {20'd0, e});
      end
      if (ref_q.size() > 0) check("spec_result", {24'd0, ALU_Out}, {24'd0, ref_q.pop_front()});
    end
    if (in_valid && in_ready) begin
      accepted++;
      exp_q.push_back(model(A, B, ALU_Sel));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0;
    int dlv0;
    rst_n = 1'b0; in_valid = 1'b0; A = 8'h00; B = 8'h00; ALU_Sel = 4'h0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {20'd0, ALU_Out, CarryOut, Zero, Overflow, Negative}, 32'd0);
    #4;
    rst_n = 1'b1;

    // Opcode sweep, back-to-back, first accept on the first edge after reset release.
    in_valid = 1'b1; A = 8'h0F; B = 8'h0A;
    for (int i = 0; i < 16; i++) begin
      ALU_Sel = i[3:0];
      ref_q.push_back(sweep_ref[i]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("sweep_accepted", accepted, 32'd16);
    check("sweep_delivered", delivered, 32'd16);
    drain();

    // Boundary cases.
    in_valid = 1'b1;
    A = 8'hFF; B = 8'h01; ALU_Sel = 4'h0;
`ifdef ALU_SAT_EN
    ref_q.push_back(8'hFF);
`else
    ref_q.push_back(8'h00);
`endif
    tick();
    A = 8'h80; B = 8'h01; ALU_Sel = 4'h1; ref_q.push_back(8'h7F); tick();
    A = 8'h37; B = 8'h00; ALU_Sel = 4'h3; ref_q.push_back(8'hFF); tick();
    A = 8'h01; B = 8'h02; ALU_Sel = 4'h1; ref_q.push_back(8'h00 | model(8'h01, 8'h02, 4'h1) >> 4); tick();
    A = 8'h7F; B = 8'h01; ALU_Sel = 4'h0; ref_q.push_back(8'h80); tick();
    A = 8'h20; B = 8'h10; ALU_Sel = 4'h2; ref_q.push_back(8'h00); tick();
    drain();

    // Backpressure: only two operand sets fit while the output is stalled.
    acc0 = accepted;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      A = 8'(i * 17 + 3); B = 8'(i + 1); ALU_Sel = 4'(i + 8);
      tick();
    end
    check("bp_accepted", accepted - acc0, 32'd2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; dlv0 = delivered;
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) tick();
    check("bp_delivered", delivered - dlv0, 32'd2);
    check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Random traffic with random stalls.
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      A = 8'($urandom);
      B = (i % 7 == 0) ? 8'h00 : 8'($urandom);
      ALU_Sel = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with both stages full: everything clears at once and nothing stale emerges.
    out_ready = 1'b0; in_valid = 1'b1; ALU_Sel = 4'h0;
    A = 8'h01; B = 8'h02; tick();
    A = 8'h03; tick();
    in_valid = 1'b0;
    check("mid_full", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_outputs", {20'd0, ALU_Out, CarryOut, Zero, Overflow, Negative}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete(); ref_q.delete(); hold_pend = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1; A = 8'h05; B = 8'h06; ALU_Sel = 4'h0; ref_q.push_back(8'h0B);
    tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set presented.
REQ-005 SHALL have port: in_ready  output  1  block accepts operand set this cycle.
REQ-006 SHALL have ports: A  input  WIDTH  operand A; B  input  WIDTH  operand B; ALU_Sel  input  4  opcode.
REQ-007 SHALL have ports: ALU_Out  output  WIDTH  result; CarryOut, Zero, Overflow, Negative  output  1 each  flags.
REQ-008 SHALL have ports: out_valid  output  1  result valid; out_ready  input  1  downstream accepts result.

Function
REQ-009 SHALL accept a transfer when in_valid&&in_ready; SHALL deliver a result when out_valid&&out_ready.
REQ-010 SHALL be a 2-stage pipeline: S1 registers A/B/ALU_Sel, S2 registers result+flags; latency 2 cycles from accept to out_valid, throughput 1/cycle.
REQ-011 S2 advance = !s2_valid || out_ready; S1 advance = !s1_valid || S2 advance; in_ready = S1 advance (combinational, no dependency on in_valid).
REQ-012 SHALL hold ALU_Out, flags and out_valid stable while out_valid && !out_ready; no result dropped or duplicated.
REQ-013 Opcodes: 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (unsigned quotient), 4 SHL by 1, 5 SHR by 1 (logical), 6 ROL by 1, 7 ROR by 1, 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR, E GT (1 if A>B unsigned else 0), F EQ (1 if A==B else 0).
REQ-014 CarryOut: ADD = carry out of MSB; SUB = borrow (A<B unsigned); SHL = A[WIDTH-1]; SHR = A[0]; all other ops 0.
REQ-015 Overflow: ADD/SUB = two's-complement signed overflow; MUL = 1 if upper WIDTH bits of full product nonzero; DIV = 1 on B==0; others 0.
REQ-016 DIV with B==0 SHALL return all-ones result, CarryOut=0, Overflow=1.
REQ-017 Zero = (ALU_Out==0); Negative = ALU_Out[WIDTH-1]; both computed on the final (post-saturation) result.
REQ-018 Simultaneous accept and deliver in one cycle SHALL sustain full throughput without bubble.
REQ-019 Outputs ALU_Out/flags are don't-care-free: SHALL be zero whenever out_valid==0.

Reset
REQ-020 rst_n low SHALL immediately clear s1_valid, s2_valid, ALU_Out, all flags to 0, regardless of clk.
REQ-021 in_ready SHALL read 1 during and after reset (pipeline empty); in-flight operations at reset assertion SHALL be discarded, never delivered.
REQ-022 First accept SHALL be possible on the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 Macro ALU_SAT_EN defined: ADD saturates to all-ones on carry, SUB saturates to 0 on borrow; CarryOut/Overflow still report the raw unsaturated condition.
REQ-024 Macro ALU_SAT_EN undefined: ADD/SUB wrap modulo 2^WIDTH; all other ops identical in both builds.

Verification (WIDTH=8)
REQ-025 A=0x0F, B=0x0A, ALU_Sel swept 0..F back-to-back, out_ready=1 -> results 0x19,0x05,0x96,0x01,0x1E,0x07,0x1E,0x87,0x0A,0x0F,0x05,0xF0,0xF5,0xFA,0x01,0x00 on 16 consecutive cycles starting 2 cycles after first accept.
REQ-026 ADD A=0xFF,B=0x01 -> without ALU_SAT_EN: 0x00, CarryOut=1, Zero=1, Overflow=0; with ALU_SAT_EN: 0xFF, CarryOut=1, Zero=0, Negative=1.
REQ-027 SUB A=0x80,B=0x01 -> 0x7F, CarryOut=0, Overflow=1, Negative=0; DIV A=0x37,B=0x00 -> 0xFF, Overflow=1.
REQ-028 Backpressure: out_ready=0 while feeding 4 ops -> exactly 2 accepted, in_ready=0 thereafter; out_ready=1 -> both delivered in order, unchanged, then in_ready=1.
REQ-029 Reset mid-operation: assert rst_n=0 for a partial cycle with both stages valid -> out_valid, ALU_Out, flags =0 immediately; after release no stale result appears.
